// File: rtl/button_event_decoder.sv
// Multi-channel pushbutton gesture decoder: synchronises and debounces each raw button, then
// classifies presses as short, long, double or auto-repeat, emitting one-cycle event pulses.
module button_event_decoder #(
   parameter int unsigned N_BTN          = 1,
   parameter int unsigned DEBOUNCE_CYC   = 20,
   parameter int unsigned LONG_CYC       = 1500,
   parameter int unsigned DOUBLE_WIN_CYC = 300,
   parameter int unsigned REPEAT_CYC     = 250
) (
   input  logic             clk_1khz_i,
   input  logic             rst_i,
   input  logic [N_BTN-1:0] pushbutton_i,
   output logic [N_BTN-1:0] held_o,
   output logic [N_BTN-1:0] short_press_o,
   output logic [N_BTN-1:0] long_press_o,
   output logic [N_BTN-1:0] double_press_o,
   output logic [N_BTN-1:0] repeat_o
);

   localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYC + 1);
   localparam int unsigned ARM_W  = $clog2(DEBOUNCE_CYC + 3);
   localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
   localparam int unsigned GAP_W  = (DOUBLE_WIN_CYC == 0) ? 1 : $clog2(DOUBLE_WIN_CYC + 1);
   localparam int unsigned REP_W  = (REPEAT_CYC == 0) ? 1 : $clog2(REPEAT_CYC + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
   localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(DEBOUNCE_CYC + 2);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((DOUBLE_WIN_CYC == 0) ? 0 : DOUBLE_WIN_CYC - 1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_CYC == 0) ? 0 : REPEAT_CYC - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPressed,
      StLongHeld,
      StWaitSecond,
      StSecondPressed
   } state_e;

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      logic              sync1;
      logic              sync2;
      logic              held;
      logic              armed;
      logic [DEB_W-1:0]  deb_cnt;
      logic [ARM_W-1:0]  arm_cnt;
      logic [HOLD_W-1:0] hold_cnt;
      logic [GAP_W-1:0]  gap_cnt;
      logic [REP_W-1:0]  rep_cnt;
      logic              short_p;
      logic              long_p;
      logic              double_p;
      logic              repeat_p;
      state_e            state;
      logic              toggle;
      logic              rise;
      logic              fall;

      // rise/fall describe the edge that held takes on this clock, so events land on cycle 0
      assign toggle = (sync2 != held) && (deb_cnt == DEB_LAST);
      assign rise   = toggle && !held;
      assign fall   = toggle && held;

      always_ff @(posedge clk_1khz_i) begin
         if (rst_i) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            held     <= 1'b0;
            armed    <= 1'b0;
            deb_cnt  <= '0;
            arm_cnt  <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            rep_cnt  <= '0;
            short_p  <= 1'b0;
            long_p   <= 1'b0;
            double_p <= 1'b0;
            repeat_p <= 1'b0;
            state    <= StIdle;
         end else begin
            sync1 <= pushbutton_i[i];
            sync2 <= sync1;

            if (sync2 == held) begin
               deb_cnt <= '0;
            end else if (toggle) begin
               held    <= ~held;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + DEB_W'(1);
            end

            // Arm only after the input has been seen low long enough to outlast the reset
            // zeros still sitting in the synchroniser.
            if (sync2) begin
               arm_cnt <= '0;
            end else if (arm_cnt != ARM_LAST) begin
               arm_cnt <= arm_cnt + ARM_W'(1);
            end
            if (arm_cnt == ARM_LAST) begin
               armed <= 1'b1;
            end

            short_p  <= 1'b0;
            long_p   <= 1'b0;
            double_p <= 1'b0;
            repeat_p <= 1'b0;

            unique case (state)
               StIdle: begin
                  if (rise && armed) begin
                     state    <= StPressed;
                     hold_cnt <= '0;
                  end
               end
               StPressed: begin
                  if (fall) begin
                     if (DOUBLE_WIN_CYC != 0) begin
                        state   <= StWaitSecond;
                        gap_cnt <= '0;
                     end else begin
                        short_p <= 1'b1;
                        state   <= StIdle;
                     end
                  end else if (hold_cnt == HOLD_LAST) begin
                     long_p  <= 1'b1;
                     state   <= StLongHeld;
                     rep_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
               StWaitSecond: begin
                  // A rise landing exactly at the window edge is too late for a double; the
                  // first press resolves as short and the rise starts a fresh press.
                  if (gap_cnt == GAP_LAST) begin
                     short_p <= 1'b1;
                     if (rise) begin
                        state    <= StPressed;
                        hold_cnt <= '0;
                     end else begin
                        state <= StIdle;
                     end
                  end else if (rise) begin
                     state <= StSecondPressed;
                  end else begin
                     gap_cnt <= gap_cnt + GAP_W'(1);
                  end
               end
               StSecondPressed: begin
                  if (fall) begin
                     double_p <= 1'b1;
                     state    <= StIdle;
                  end
               end
               StLongHeld: begin
                  if (fall) begin
                     state <= StIdle;
                  end else if (REPEAT_CYC != 0) begin
                     if (rep_cnt == REP_LAST) begin
                        repeat_p <= 1'b1;
                        rep_cnt  <= '0;
                     end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                     end
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end

      assign held_o[i]         = held;
      assign short_press_o[i]  = short_p;
      assign long_press_o[i]   = long_p;
      assign double_press_o[i] = double_p;
      assign repeat_o[i]       = repeat_p;
   end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: a timeline-level reference model queues every
// expected held edge and event pulse; a negedge monitor matches DUT outputs against the queue.
module tb_button_event_decoder;

   localparam int D = 4;
   localparam int L = 50;
   localparam int W = 20;
   localparam int R = 10;

   localparam int K_RISE   = 0;
   localparam int K_FALL   = 1;
   localparam int K_SHORT  = 2;
   localparam int K_LONG   = 3;
   localparam int K_DOUBLE = 4;
   localparam int K_REP    = 5;
   localparam logic [5:0] EVT = 6'b111100;

   typedef struct {
      int cyc;
      int ch;
      int kind;
   } ev_t;

   logic       clk;
   logic       rst;
   logic [1:0] btn;
   logic [1:0] held_o;
   logic [1:0] short_press_o;
   logic [1:0] long_press_o;
   logic [1:0] double_press_o;
   logic [1:0] repeat_o;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   ev_t  exq[$];
   int   dcnt[2][6];
   int   base[2][6];

   // Reference model state, per channel
   logic         d1[2];
   logic         d2[2];
   logic [D-1:0] sh[2];
   int           fill[2];
   logic         m_held[2];
   int           low_run[2];
   bit           arm_seen[2];
   bit           active[2];
   bit           second[2];
   bit           longm[2];
   bit           wait_on[2];
   int           rise_t[2];
   int           fall_t[2];

   button_event_decoder #(
      .N_BTN         (2),
      .DEBOUNCE_CYC  (D),
      .LONG_CYC      (L),
      .DOUBLE_WIN_CYC(W),
      .REPEAT_CYC    (R)
   ) dut (
      .clk_1khz_i    (clk),
      .rst_i         (rst),
      .pushbutton_i  (btn),
      .held_o        (held_o),
      .short_press_o (short_press_o),
      .long_press_o  (long_press_o),
      .double_press_o(double_press_o),
      .repeat_o      (repeat_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic string kname(input int k);
      case (k)
         K_RISE:   return "held_rise";
         K_FALL:   return "held_fall";
         K_SHORT:  return "short_press";
         K_LONG:   return "long_press";
         K_DOUBLE: return "double_press";
         default:  return "repeat";
      endcase
   endfunction

   task automatic push(input int n, input int ch, input int k);
      ev_t e;
      e.cyc  = n;
      e.ch   = ch;
      e.kind = k;
      exq.push_back(e);
   endtask

   // One cycle of the gesture rules, phrased as elapsed time since the last held edges.
   task automatic model_step(input int ch, input int n, input logic r, input logic raw);
      logic s2;
      logic nh;
      bit   is_rise;
      bit   is_fall;
      bit   armed_n;
      bit   consumed;
      if (r) begin
         if (m_held[ch]) push(n, ch, K_FALL);
         m_held[ch]   = 1'b0;
         d1[ch]       = 1'b0;
         d2[ch]       = 1'b0;
         sh[ch]       = '0;
         fill[ch]     = 0;
         low_run[ch]  = 0;
         arm_seen[ch] = 0;
         active[ch]   = 0;
         second[ch]   = 0;
         longm[ch]    = 0;
         wait_on[ch]  = 0;
         return;
      end
      s2     = d2[ch];
      d2[ch] = d1[ch];
      d1[ch] = raw;
      sh[ch] = {sh[ch][D-2:0], s2};
      if (fill[ch] < D) fill[ch]++;
      nh = m_held[ch];
      if (fill[ch] >= D && sh[ch] == {D{~m_held[ch]}}) nh = ~m_held[ch];
      is_rise    = nh && !m_held[ch];
      is_fall    = !nh && m_held[ch];
      m_held[ch] = nh;
      if (is_rise) push(n, ch, K_RISE);
      if (is_fall) push(n, ch, K_FALL);

      armed_n = arm_seen[ch];
      if (s2) low_run[ch] = 0;
      else low_run[ch]++;
      if (low_run[ch] >= D + 2) arm_seen[ch] = 1;

      if (active[ch] && !second[ch] && !longm[ch] && nh && (n - rise_t[ch] == L)) begin
         push(n, ch, K_LONG);
         longm[ch] = 1;
      end else if (active[ch] && longm[ch] && nh && (n - rise_t[ch] > L) &&
                   ((n - rise_t[ch] - L) % R == 0)) begin
         push(n, ch, K_REP);
      end

      if (is_fall && active[ch]) begin
         if (second[ch]) begin
            push(n, ch, K_DOUBLE);
         end else if (!longm[ch]) begin
            wait_on[ch] = 1;
            fall_t[ch]  = n;
         end
         active[ch] = 0;
         second[ch] = 0;
         longm[ch]  = 0;
      end

      consumed = 0;
      if (wait_on[ch]) begin
         if (is_rise && (n - fall_t[ch] < W)) begin
            wait_on[ch] = 0;
            active[ch]  = 1;
            second[ch]  = 1;
            rise_t[ch]  = n;
            consumed    = 1;
         end else if (n - fall_t[ch] == W) begin
            push(n, ch, K_SHORT);
            wait_on[ch] = 0;
         end
      end
      if (is_rise && !consumed && !active[ch] && !wait_on[ch] && armed_n) begin
         active[ch] = 1;
         second[ch] = 0;
         longm[ch]  = 0;
         rise_t[ch] = n;
      end
   endtask

   initial begin
      for (int ch = 0; ch < 2; ch++) begin
         d1[ch] = 0; d2[ch] = 0; sh[ch] = '0; fill[ch] = 0; m_held[ch] = 0;
         low_run[ch] = 0; arm_seen[ch] = 0; active[ch] = 0; second[ch] = 0;
         longm[ch] = 0; wait_on[ch] = 0; rise_t[ch] = 0; fall_t[ch] = 0;
      end
      forever begin
         @(posedge clk);
         cyc++;
         for (int ch = 0; ch < 2; ch++) model_step(ch, cyc, rst, btn[ch]);
      end
   end

   // Monitor: every DUT held edge or pulse must match a queued expectation for this cycle.
   initial begin
      logic [1:0] prev_held;
      logic       b;
      int         idx;
      prev_held = 2'b00;
      for (int ch = 0; ch < 2; ch++)
         for (int k = 0; k < 6; k++) dcnt[ch][k] = 0;
      forever begin
         @(negedge clk);
         for (int ch = 0; ch < 2; ch++) begin
            for (int k = 0; k < 6; k++) begin
               case (k)
                  K_RISE:   b = held_o[ch] && !prev_held[ch];
                  K_FALL:   b = !held_o[ch] && prev_held[ch];
                  K_SHORT:  b = short_press_o[ch];
                  K_LONG:   b = long_press_o[ch];
                  K_DOUBLE: b = double_press_o[ch];
                  default:  b = repeat_o[ch];
               endcase
               if (b === 1'b1) begin
                  dcnt[ch][k]++;
                  checks++;
                  idx = -1;
                  for (int i = 0; i < exq.size(); i++) begin
                     if (exq[i].cyc == cyc && exq[i].ch == ch && exq[i].kind == k) begin
                        idx = i;
                        break;
                     end
                  end
                  if (idx >= 0) begin
                     exq.delete(idx);
                  end else begin
                     errors++;
                     $display("FAIL unexpected %s ch%0d cyc %0d: got 1 expected 0",
                              kname(k), ch, cyc);
                  end
               end
            end
         end
         prev_held = held_o;
         while (exq.size() > 0 && exq[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing %s ch%0d cyc %0d: got 0 expected 1",
                     kname(exq[0].kind), exq[0].ch, exq[0].cyc);
            void'(exq.pop_front());
         end
      end
   end

   task automatic hold(input logic [1:0] v, input int n);
      btn = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic mark();
      base = dcnt;
   endtask

   task automatic expect_cnt(input string name, input int ch, input logic [5:0] kinds,
                             input int exp);
      int got;
      got = 0;
      for (int k = 0; k < 6; k++) if (kinds[k]) got += dcnt[ch][k] - base[ch][k];
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s ch%0d: got %0d expected %0d", name, ch, got, exp);
      end
   endtask

   task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   initial begin
      int dur;
      rst = 1'b1;
      btn = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_held", held_o, 2'b00);
      chk("reset_short", short_press_o, 2'b00);
      chk("reset_long", long_press_o, 2'b00);
      chk("reset_double", double_press_o, 2'b00);
      chk("reset_repeat", repeat_o, 2'b00);

      // Buttons still high out of reset must not produce events until re-pressed
      rst = 1'b0;
      mark();
      hold(2'b11, 30);
      expect_cnt("unarmed_events", 0, EVT, 0);
      expect_cnt("unarmed_events", 1, EVT, 0);
      hold(2'b00, 30);
      mark();
      hold(2'b11, 10);
      hold(2'b00, 40);
      expect_cnt("rearmed_short", 0, 6'b000100, 1);
      expect_cnt("rearmed_short", 1, 6'b000100, 1);

      // Bounce rejection
      mark();
      hold(2'b01, 1); hold(2'b00, 1); hold(2'b01, 1); hold(2'b00, 1);
      hold(2'b01, 11);
      hold(2'b00, 40);
      expect_cnt("bounce_rises", 0, 6'b000001, 1);
      expect_cnt("bounce_short", 0, 6'b000100, 1);
      expect_cnt("bounce_events", 0, EVT, 1);

      // Short press
      mark();
      hold(2'b01, 10);
      hold(2'b00, 40);
      expect_cnt("short_short", 0, 6'b000100, 1);
      expect_cnt("short_others", 0, 6'b111000, 0);

      // Long press with repeats
      mark();
      hold(2'b10, 80);
      hold(2'b00, 40);
      expect_cnt("long_long", 1, 6'b001000, 1);
      expect_cnt("long_repeat", 1, 6'b100000, 2);
      expect_cnt("long_short", 1, 6'b010100, 0);

      // Double press, then a gap too wide to pair
      mark();
      hold(2'b01, 10); hold(2'b00, 8); hold(2'b01, 10);
      hold(2'b00, 40);
      expect_cnt("double_double", 0, 6'b010000, 1);
      expect_cnt("double_short", 0, 6'b000100, 0);
      mark();
      hold(2'b01, 10); hold(2'b00, 25); hold(2'b01, 10);
      hold(2'b00, 40);
      expect_cnt("wide_gap_short", 0, 6'b000100, 2);
      expect_cnt("wide_gap_double", 0, 6'b010000, 0);

      // Simultaneous long presses
      mark();
      hold(2'b11, 60);
      hold(2'b00, 40);
      expect_cnt("simul_long", 0, 6'b001000, 1);
      expect_cnt("simul_long", 1, 6'b001000, 1);

      // Reset mid-press aborts the gesture
      mark();
      hold(2'b01, 36);
      rst = 1'b1;
      hold(2'b01, 1);
      rst = 1'b0;
      hold(2'b01, 20);
      hold(2'b00, 40);
      expect_cnt("aborted_events", 0, EVT, 0);
      mark();
      hold(2'b01, 10);
      hold(2'b00, 40);
      expect_cnt("post_abort_short", 0, 6'b000100, 1);

      // Randomised segments, including sub-debounce glitches
      for (int s = 0; s < 60; s++) begin
         if ($urandom_range(0, 7) == 0) dur = int'($urandom_range(1, 3));
         else dur = int'($urandom_range(5, 70));
         hold(2'($urandom_range(0, 3)), dur);
      end
      hold(2'b00, 60);

      checks++;
      if (exq.size() != 0) begin
         errors++;
         $display("FAIL queue_drained: got %0d pending expected 0", exq.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Multi-channel successor to pushbutton_processor for the scoreboard.
- Per channel: synchronises and debounces a raw pushbutton, then classifies each gesture as short press, long press, double press or auto-repeat while held.
- Emits one-cycle event pulses that feed the score counters, so one or more players can increment, decrement or reset with a single button each.
- Sits between the board pins and the counter logic in scoreboard_top's successor.

Parameters:
- N_BTN, 1: number of independent button channels.
- DEBOUNCE_CYC, 20: consecutive stable cycles required before the debounced level changes (20 ms at 1 kHz).
- LONG_CYC, 1500: held cycles before long_press_o fires (1.5 s).
- DOUBLE_WIN_CYC, 300: maximum released gap for a second press to count as a double press. 0 disables double detection.
- REPEAT_CYC, 250: auto-repeat period after long press. 0 disables repeat.

Ports:
- clk_1khz_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- pushbutton_i  in  N_BTN  raw asynchronous buttons, active high.
- held_o  out  N_BTN  debounced button level.
- short_press_o  out  N_BTN  one-cycle pulse per short press.
- long_press_o  out  N_BTN  one-cycle pulse when the long threshold is reached.
- double_press_o  out  N_BTN  one-cycle pulse per double press.
- repeat_o  out  N_BTN  one-cycle pulse each repeat period during a long hold.

Behaviour:
- Single clock domain (clk_1khz_i). Reset is synchronous, active-high (rst_i).
- Channels are fully independent. Bit i of every output belongs to pushbutton_i[i].
- Reset:
  - All outputs are 0.
  - Synchroniser flops, debounced levels, FSMs and counters are cleared.
  - Reset asserted mid-gesture aborts that gesture with no pulse.
  - After reset, a button that is still high must first be seen debounced-low before a new press is recognised (arm flag).
- Synchroniser: two flops per channel.
- Debounce:
  - The counter increments while the synchronised input differs from held_o, and clears when they match.
  - When it reaches DEBOUNCE_CYC, held_o toggles and the counter clears.
  - A clean raw edge reaches held_o exactly DEBOUNCE_CYC+2 cycles later.
  - A pulse shorter than DEBOUNCE_CYC cycles is ignored.
- Timing reference: in the rules below, "rise" and "fall" mean held_o edges. Cycle 0 is the first cycle held_o has its new value.
- FSM per channel. States: IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED.
  - IDLE:
    - On rise (when armed), go to PRESSED and clear the hold counter.
  - PRESSED:
    - The hold counter increments each cycle.
    - If still high at cycle LONG_CYC after rise: pulse long_press_o that cycle, go to LONG_HELD, clear the repeat counter.
    - Fall before that with DOUBLE_WIN_CYC>0: go to WAIT_SECOND and clear the gap counter.
    - Fall before that with DOUBLE_WIN_CYC=0: pulse short_press_o at fall cycle 0, go to IDLE.
  - WAIT_SECOND:
    - The gap counter increments each cycle.
    - A rise at gap < DOUBLE_WIN_CYC goes to SECOND_PRESSED.
    - Otherwise, at fall cycle DOUBLE_WIN_CYC: pulse short_press_o, go to IDLE.
  - SECOND_PRESSED:
    - Wait for fall, with no long detection.
    - At fall cycle 0: pulse double_press_o, go to IDLE.
  - LONG_HELD:
    - If REPEAT_CYC>0, pulse repeat_o at rise cycles LONG_CYC + k*REPEAT_CYC (k≥1) while held.
    - On fall, go to IDLE with no pulse.
- At most one event output is high per channel per cycle. Pulses are exactly one cycle wide.
- Counters are sized with $clog2 of their maximum value plus 1. They saturate and never wrap.
- The hold counter stops once the FSM leaves PRESSED.
- Outputs are registered: each pulse appears on the cycle stated above, aligned with the held_o timeline.

Test Plan (N_BTN=2, DEBOUNCE_CYC=4, LONG_CYC=50, DOUBLE_WIN_CYC=20, REPEAT_CYC=10):
- Reset:
  - Stimulus: hold rst_i for 3 cycles with pushbutton_i=2'b11.
  - Required: all outputs 0.
  - Stimulus: release reset with buttons still high.
  - Required: no events until each button goes low, then is pressed again.
- Bounce rejection:
  - Stimulus: channel 0 raw toggles 1,0,1,0,1 on single cycles, then stays high 10 cycles, then low.
  - Required: held_o rises once, 6 cycles after the last 0→1 raw edge.
  - Required: exactly one short_press_o, 20 cycles after the held_o fall.
- Short press:
  - Stimulus: channel 0 clean 10-cycle press.
  - Required: held_o high for 10 cycles; short_press_o single pulse at fall+20; long, double and repeat stay 0.
- Long press:
  - Stimulus: channel 1 clean 80-cycle press.
  - Required: long_press_o at rise+50; repeat_o at rise+60 and rise+70 (two pulses); no short_press_o on release.
- Double press:
  - Stimulus: channel 0 presses of 10 cycles, then 8 cycles low, then 10 cycles.
  - Required: one double_press_o at the second fall; no short_press_o.
  - Stimulus: repeat with a 25-cycle gap.
  - Required: two short_press_o pulses.
- Simultaneous and reset mid-press:
  - Stimulus: both channels pressed together for 60 cycles.
  - Required: both long_press_o pulses fire in the same cycle.
  - Stimulus: pulse rst_i at rise+30 of a new press.
  - Required: no pulse on release; the next clean press is decoded normally.
